// File: rtl/dmem_responder.sv
// dmem_responder: handshaked word-wide data memory for the multicycle CPU's
// MEM phase. Accepts one request at a time, waits WAIT cycles, performs the
// access, then pulses ack for one cycle with rdata valid alongside it.
// Optional feature macro: DMEM_ERR_EN adds an err output. Requests whose
// upper address bits are non-zero then skip the storage access and return
// 16'hDEAD. Without the macro, upper address bits are ignored and addresses
// wrap modulo the storage depth.
// ADDR_W is expected to be in 1..15 and WAIT in 0..15.

module dmem_responder #(
   parameter int ADDR_W = 8,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic [15:0] rdata
`ifdef DMEM_ERR_EN
   ,
   output logic        err
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int         DEPTH  = 1 << ADDR_W;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [15:0]       lat_wdata;
   logic              lat_oob;
   logic              access;
   logic              oob_in;

   logic [15:0]       mem [DEPTH];

`ifdef DMEM_ERR_EN
   // Out-of-range requests are flagged at accept time and never touch storage.
   assign oob_in = (addr >> ADDR_W) != 16'h0000;
`else
   // Upper address bits are intentionally ignored so addresses alias.
   logic unused_upper;
   assign oob_in       = 1'b0;
   assign unused_upper = ^addr[15:ADDR_W];
`endif

   // The access happens on the last BUSY cycle, once the wait count is spent.
   assign access = (state == S_BUSY) && (cnt == 4'd0);

   // Handshake outputs decode directly from the state register.
   assign ready = (state == S_IDLE);
   assign ack   = (state == S_RESP);
`ifdef DMEM_ERR_EN
   assign err   = ack && lat_oob;
`endif

   // Control FSM: latch the request, count wait states, capture read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         rdata   <= 16'h0000;
         lat_oob <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  lat_we    <= we;
                  lat_addr  <= addr[ADDR_W-1:0];
                  lat_wdata <= wdata;
                  lat_oob   <= oob_in;
                  cnt       <= 4'(WAIT);
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= S_RESP;
                  if (lat_oob) begin
                     rdata <= 16'hDEAD;
                  end else if (lat_we) begin
                     rdata <= lat_wdata;
                  end else begin
                     rdata <= mem[lat_addr];
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Storage write port; reset suppresses a pending write and never clears contents.
   always_ff @(posedge clk) begin
      if (rst && access && lat_we && !lat_oob) begin
         mem[lat_addr] <= lat_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// A behavioural memory model (plain array plus known flags) predicts every
// read; handshake timing is predicted from WAIT directly.
// Build with +define+DMEM_ERR_EN to exercise the out-of-range error path.

module tb_dmem_responder;

   localparam int TB_WAIT   = 2;
   localparam int TB_ADDR_W = 8;
   localparam int TB_DEPTH  = 1 << TB_ADDR_W;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ready;
   logic        ack;
   logic [15:0] rdata;
   logic        err;

   int n_tests;
   int n_fail;

   logic [15:0] model_mem [TB_DEPTH];
   bit          model_known [TB_DEPTH];

`ifdef DMEM_ERR_EN
   dmem_responder #(.ADDR_W(TB_ADDR_W), .WAIT(TB_WAIT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready), .ack(ack), .rdata(rdata), .err(err)
   );
`else
   dmem_responder #(.ADDR_W(TB_ADDR_W), .WAIT(TB_WAIT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready), .ack(ack), .rdata(rdata)
   );
   assign err = 1'b0;
`endif

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference memory behaviour: returns expected rdata/err and whether rdata is predictable.
   function automatic void model_access(input logic mwe, input logic [15:0] maddr,
                                        input logic [15:0] mwdata, output logic [15:0] er,
                                        output logic ee, output bit ek);
      int idx;
      bit oob;
      idx = int'(maddr) % TB_DEPTH;
`ifdef DMEM_ERR_EN
      oob = int'(maddr) >= TB_DEPTH;
`else
      oob = 1'b0;
`endif
      ee = 1'b0;
      ek = 1'b1;
      if (oob) begin
         er = 16'hDEAD;
         ee = 1'b1;
      end else if (mwe) begin
         model_mem[idx]   = mwdata;
         model_known[idx] = 1'b1;
         er = mwdata;
      end else begin
         er = model_mem[idx];
         ek = model_known[idx];
      end
   endfunction

   // Issues one request and reports what the DUT did; comparisons live in the callers.
   task automatic do_txn(input logic t_we, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                         input bit scramble, output int lat, output logic [15:0] r,
                         output logic e, output logic ack_after, output logic ready_after,
                         output logic busy_ready);
      lat = -1;
      r = 16'hxxxx;
      e = 1'bx;
      ack_after = 1'bx;
      ready_after = 1'bx;
      busy_ready = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 50 && ready !== 1'b1; n++) @(negedge clk);
      if (ready !== 1'b1) return;
      req = 1'b1;
      we = t_we;
      addr = t_addr;
      wdata = t_wdata;
      @(posedge clk);
      #1;
      req = 1'b0;
      if (scramble) begin
         addr = 16'h0000;
         wdata = 16'hFFFF;
         we = ~t_we;
      end
      for (int k = 1; k <= 20; k++) begin
         if (ready !== 1'b0) busy_ready = 1'b1;
         @(posedge clk);
         #1;
         if (ack === 1'b1) begin
            lat = k;
            r = rdata;
            e = err;
            break;
         end
      end
      if (lat < 0) return;
      @(posedge clk);
      #1;
      ack_after = ack;
      ready_after = ready;
   endtask

   // Reset with a pending request: reset wins, outputs idle, nothing accepted.
   task automatic test_reset;
      rst = 1'b0;
      req = 1'b1;
      we = 1'b1;
      addr = 16'h0077;
      wdata = 16'h1357;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack got %b want 0", ack); end
      n_tests++; if (rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rdata got %h want 0000", rdata); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", err); end
      @(negedge clk);
      req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_dropped ready got %b want 1", ready); end
      for (int k = 0; k < TB_WAIT + 3; k++) begin
         @(posedge clk);
         #1;
         n_tests++; if (ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_ack cycle %0d got %b want 0", k, ack); end
      end
   endtask

   // Single write then read-back of the same word, with full handshake timing.
   task automatic test_write_read;
      int lat;
      logic [15:0] r, er;
      logic e, ee, aa, ra, br;
      bit ek;
      model_access(1'b1, 16'h0010, 16'hBEEF, er, ee, ek);
      do_txn(1'b1, 16'h0010, 16'hBEEF, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (lat != TB_WAIT + 1) begin n_fail++; $display("[TB] FAIL wr_latency got %0d want %0d", lat, TB_WAIT + 1); end
      n_tests++; if (br !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_ready_busy got %b want 0", br); end
      n_tests++; if (aa !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_ack_fall got %b want 0", aa); end
      n_tests++; if (ra !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_ready_rise got %b want 1", ra); end
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL wr_rdata got %h want %h", r, er); end
      model_access(1'b0, 16'h0010, 16'h0000, er, ee, ek);
      do_txn(1'b0, 16'h0010, 16'h0000, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (lat != TB_WAIT + 1) begin n_fail++; $display("[TB] FAIL rd_latency got %0d want %0d", lat, TB_WAIT + 1); end
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL rd_rdata got %h want %h", r, er); end
      n_tests++; if (aa !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_ack_fall got %b want 0", aa); end
      n_tests++; if (e !== ee) begin n_fail++; $display("[TB] FAIL rd_err got %b want %b", e, ee); end
   endtask

   // req held high continuously: one accept per WAIT+3 cycles, others ignored.
   task automatic test_back_to_back;
      int p;
      logic [15:0] exp_r, er, r;
      logic ee, e, aa, ra, br;
      bit ek;
      int lat;
      p = TB_WAIT + 3;
      exp_r = 16'h0000;
      @(negedge clk);
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_start_ready got %b want 1", ready); end
      for (int k = 0; k < 20; k++) begin
         req = 1'b1;
         we = 1'b1;
         addr = (k % 2 == 0) ? 16'h0001 : 16'h0002;
         wdata = 16'h3000 + 16'(k);
         if (k % p == 0) begin
            exp_r = wdata;
            model_access(1'b1, addr, wdata, er, ee, ek);
         end
         @(posedge clk);
         #1;
         n_tests++; if (ack !== ((k % p) == p - 2)) begin n_fail++; $display("[TB] FAIL b2b_ack edge %0d got %b", k, ack); end
         n_tests++; if (ready !== ((k % p) == p - 1)) begin n_fail++; $display("[TB] FAIL b2b_ready edge %0d got %b", k, ready); end
         if ((k % p) == p - 2) begin
            n_tests++; if (rdata !== exp_r) begin n_fail++; $display("[TB] FAIL b2b_rdata edge %0d got %h want %h", k, rdata, exp_r); end
         end
         @(negedge clk);
      end
      req = 1'b0;
      for (int a = 1; a <= 2; a++) begin
         model_access(1'b0, 16'(a), 16'h0000, er, ee, ek);
         do_txn(1'b0, 16'(a), 16'h0000, 1'b0, lat, r, e, aa, ra, br);
         n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL b2b_readback addr %0d got %h want %h", a, r, er); end
      end
   endtask

   // Bus changes after accept must not affect the transaction in flight.
   task automatic test_input_hold;
      int lat;
      logic [15:0] r, er;
      logic e, ee, aa, ra, br;
      bit ek;
      model_access(1'b1, 16'h0000, 16'h0F0F, er, ee, ek);
      do_txn(1'b1, 16'h0000, 16'h0F0F, 1'b0, lat, r, e, aa, ra, br);
      model_access(1'b1, 16'h0020, 16'h1234, er, ee, ek);
      do_txn(1'b1, 16'h0020, 16'h1234, 1'b1, lat, r, e, aa, ra, br);
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL hold_ack_rdata got %h want %h", r, er); end
      model_access(1'b0, 16'h0020, 16'h0000, er, ee, ek);
      do_txn(1'b0, 16'h0020, 16'h0000, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL hold_readback_20 got %h want %h", r, er); end
      model_access(1'b0, 16'h0000, 16'h0000, er, ee, ek);
      do_txn(1'b0, 16'h0000, 16'h0000, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL hold_readback_00 got %h want %h", r, er); end
   endtask

   // Reset during BUSY drops the write; earlier contents survive.
   task automatic test_reset_busy;
      int lat;
      logic [15:0] r, er;
      logic e, ee, aa, ra, br;
      logic ack_seen;
      bit ek;
      model_access(1'b1, 16'h0030, 16'hAAAA, er, ee, ek);
      do_txn(1'b1, 16'h0030, 16'hAAAA, 1'b0, lat, r, e, aa, ra, br);
      ack_seen = 1'b0;
      @(negedge clk);
      req = 1'b1;
      we = 1'b1;
      addr = 16'h0030;
      wdata = 16'h5555;
      @(posedge clk);
      #1;
      req = 1'b0;
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (ack === 1'b1) ack_seen = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (TB_WAIT + 3) begin
         @(posedge clk);
         #1;
         if (ack === 1'b1) ack_seen = 1'b1;
      end
      n_tests++; if (ack_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL rstbusy_ack got %b want 0", ack_seen); end
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstbusy_ready got %b want 1", ready); end
      model_access(1'b0, 16'h0030, 16'h0000, er, ee, ek);
      do_txn(1'b0, 16'h0030, 16'h0000, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL rstbusy_readback got %h want %h", r, er); end
   endtask

   // Upper address bits: error response with the macro, aliasing without it.
   task automatic test_upper_addr;
      int lat;
      logic [15:0] r, er;
      logic e, ee, aa, ra, br;
      bit ek;
      model_access(1'b1, 16'h0005, 16'h1111, er, ee, ek);
      do_txn(1'b1, 16'h0005, 16'h1111, 1'b0, lat, r, e, aa, ra, br);
      model_access(1'b1, 16'h0105, 16'h7777, er, ee, ek);
      do_txn(1'b1, 16'h0105, 16'h7777, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL upper_wr_rdata got %h want %h", r, er); end
      n_tests++; if (e !== ee) begin n_fail++; $display("[TB] FAIL upper_wr_err got %b want %b", e, ee); end
      n_tests++; if (lat != TB_WAIT + 1) begin n_fail++; $display("[TB] FAIL upper_latency got %0d want %0d", lat, TB_WAIT + 1); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL upper_err_after got %b want 0", err); end
      model_access(1'b0, 16'h0105, 16'h0000, er, ee, ek);
      do_txn(1'b0, 16'h0105, 16'h0000, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL upper_rd_rdata got %h want %h", r, er); end
      n_tests++; if (e !== ee) begin n_fail++; $display("[TB] FAIL upper_rd_err got %b want %b", e, ee); end
      model_access(1'b0, 16'h0005, 16'h0000, er, ee, ek);
      do_txn(1'b0, 16'h0005, 16'h0000, 1'b0, lat, r, e, aa, ra, br);
      n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL alias_rd_rdata got %h want %h", r, er); end
      n_tests++; if (e !== ee) begin n_fail++; $display("[TB] FAIL alias_rd_err got %b want %b", e, ee); end
   endtask

   // Randomized reads/writes over a small window, checked against the model.
   task automatic test_random;
      int lat;
      logic [15:0] r, er, ta, td;
      logic e, ee, aa, ra, br, tw;
      bit ek;
      for (int i = 0; i < 40; i++) begin
         tw = 1'($urandom_range(0, 1));
         ta = 16'h0040 + 16'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) ta = ta | (16'($urandom_range(1, 255)) << 8);
         td = 16'($urandom);
         model_access(tw, ta, td, er, ee, ek);
         do_txn(tw, ta, td, 1'b0, lat, r, e, aa, ra, br);
         n_tests++; if (lat != TB_WAIT + 1) begin n_fail++; $display("[TB] FAIL rand_latency #%0d got %0d want %0d", i, lat, TB_WAIT + 1); end
         n_tests++; if (aa !== 1'b0 || ra !== 1'b1 || br !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_handshake #%0d ack_after %b ready_after %b ready_busy %b want 0 1 0", i, aa, ra, br); end
         n_tests++; if (e !== ee) begin n_fail++; $display("[TB] FAIL rand_err #%0d got %b want %b", i, e, ee); end
         if (ek) begin
            n_tests++; if (r !== er) begin n_fail++; $display("[TB] FAIL rand_rdata #%0d addr %h got %h want %h", i, ta, r, er); end
         end
      end
   endtask

   // Test sequence and summary.
   initial begin
      n_tests = 0;
      n_fail = 0;
      rst = 1'b0;
      req = 1'b0;
      we = 1'b0;
      addr = 16'h0000;
      wdata = 16'h0000;
      for (int i = 0; i < TB_DEPTH; i++) begin
         model_mem[i] = 16'h0000;
         model_known[i] = 1'b0;
      end
      test_reset;
      test_write_read;
      test_back_to_back;
      test_input_hold;
      test_reset_busy;
      test_upper_addr;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
